rep3_serial_encoder: RTL and testbench



---
 rtl/rep_code_pkg.sv | 17 +
 rtl/rep_bit_counter.sv | 53 +++++
 rtl/rep3_serial_encoder.sv | 105 ++++++++++
 tb/tb_rep3_serial_encoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rep_code_pkg.sv
// Shared definitions for the repetition-code encoder and its receiver.
// Holds the FSM encoding and the counter-width helper.
package rep_code_pkg;

  localparam int REP_DEFAULT = 3;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  // $clog2 returns 0 for n<=1; counters always need at least one bit
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rep_bit_counter.sv
// Two-level counter: symbol repeats within a bit, then bits within a frame.
// Flags the last repeat of a bit and the last symbol of the frame.
module rep_bit_counter
  import rep_code_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REP    = REP_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic sym_last,
  output logic frame_last
);

  localparam int RW = cnt_w(REP);
  localparam int BW = cnt_w(DATA_W);
  localparam logic [RW-1:0] REP_MAX = RW'(REP - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    sym_last   = (rep_cnt_q == REP_MAX);
    frame_last = sym_last && (bit_cnt_q == BIT_MAX);
    rep_cnt_d  = rep_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (clr) begin
      rep_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (en) begin
      if (sym_last) begin
        rep_cnt_d = '0;
        bit_cnt_d = frame_last ? '0 : bit_cnt_q + BW'(1);
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/rep3_serial_encoder.sv
// Repetition-code serializer: each word goes out LSB-first,
// every bit held on tx_bit for REP cycles.
module rep3_serial_encoder
  import rep_code_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REP    = REP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_frame,
  output logic              done
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              tx_bit_q, tx_bit_d;
  logic              tx_frame_q, tx_frame_d;
  logic              in_ready_q, in_ready_d;
  logic              done_q, done_d;

  logic hs;
  logic sym_last;
  logic frame_last;

  assign hs = in_valid && (state_q == IDLE);

  rep_bit_counter #(
    .DATA_W (DATA_W),
    .REP    (REP)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr        (hs),
    .en         (state_q == SEND),
    .sym_last   (sym_last),
    .frame_last (frame_last)
  );

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    tx_bit_d   = 1'b0;
    tx_frame_d = 1'b0;
    in_ready_d = 1'b0;
    done_d     = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (hs) begin
          state_d    = SEND;
          shreg_d    = in_data;
          tx_bit_d   = in_data[0];
          tx_frame_d = 1'b1;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      (state_q == SEND): begin
        if (frame_last) begin
          state_d    = IDLE;
          shreg_d    = '0;
          in_ready_d = 1'b1;
          done_d     = 1'b1;
        end else begin
          // Registered output shows the symbol for the coming cycle
          if (sym_last) shreg_d = shreg_q >> 1;
          tx_bit_d   = shreg_d[0];
          tx_frame_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      tx_bit_q   <= 1'b0;
      tx_frame_q <= 1'b0;
      in_ready_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      tx_bit_q   <= tx_bit_d;
      tx_frame_q <= tx_frame_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign tx_bit   = tx_bit_q;
  assign tx_frame = tx_frame_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rep3_serial_encoder.sv
// Bench for rep3_serial_encoder: REP=3 and REP=5 instances against a
// symbol-index reference model plus majority-vote word recovery.
module tb_rep3_serial_encoder;

  localparam int DW = 8;
  localparam int R0 = 3;
  localparam int R1 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [1:0][DW-1:0]  din;
  logic [1:0]          vin;
  logic [1:0]          rdy, txb, txf, dn;

  rep3_serial_encoder #(.DATA_W(DW), .REP(R0)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (din[0]),
    .in_valid (vin[0]),
    .in_ready (rdy[0]),
    .tx_bit   (txb[0]),
    .tx_frame (txf[0]),
    .done     (dn[0])
  );

  rep3_serial_encoder #(.DATA_W(DW), .REP(R1)) dut5 (
    .clk      (clk),
    .rst      (rst),
    .in_data  (din[1]),
    .in_valid (vin[1]),
    .in_ready (rdy[1]),
    .tx_bit   (txb[1]),
    .tx_frame (txf[1]),
    .done     (dn[1])
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic int rep_of(int i);
    return (i == 0) ? R0 : R1;
  endfunction

  function automatic logic [DW*R0-1:0] expand(logic [DW-1:0] w);
    logic [DW*R0-1:0] e;
    for (int k = 0; k < DW*R0; k++) e[k] = w[k/R0];
    return e;
  endfunction

  // Reference model: frame = active flag + symbol index
  bit              m_act  [2];
  int              m_idx  [2];
  logic [DW-1:0]   m_word [2];
  bit              m_done [2];
  int              started[2];
  logic [DW-1:0]   sentq  [2][$];

  // Majority-vote receiver state
  int              mon_n   [2];
  int              mon_ones[2];
  int              flip_pos[2];
  logic [DW-1:0]   mon_rec [2];
  bit              flip_en = 0;

  int              cyc = 0;
  int              flen = 0;
  int              cap_n = 0;
  bit              prev_txf = 0;
  logic [DW*R0-1:0] cap;

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i]    = 0;
        m_idx[i]    = 0;
        m_done[i]   = 0;
        mon_n[i]    = 0;
        mon_ones[i] = 0;
        mon_rec[i]  = '0;
        sentq[i].delete();
      end else begin
        m_done[i] = 0;
        if (!m_act[i]) begin
          if (vin[i]) begin
            m_act[i]  = 1;
            m_idx[i]  = 0;
            m_word[i] = din[i];
            sentq[i].push_back(din[i]);
            started[i]++;
          end
        end else begin
          m_idx[i]++;
          if (m_idx[i] == DW*rep_of(i)) begin
            m_act[i]  = 0;
            m_done[i] = 1;
          end
        end
      end
    end
    if (rst) flen = 0;

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("in_ready[%0d]", i), 32'(rdy[i]), 32'(!m_act[i]));
      chk($sformatf("tx_frame[%0d]", i), 32'(txf[i]), 32'(m_act[i]));
      chk($sformatf("tx_bit[%0d]", i), 32'(txb[i]),
          32'(m_act[i] ? m_word[i][m_idx[i]/rep_of(i)] : 1'b0));
      chk($sformatf("done[%0d]", i), 32'(dn[i]), 32'(m_done[i]));
      if (!rst && txf[i]) begin
        int p;
        logic b;
        p = mon_n[i] % rep_of(i);
        b = txb[i] ^ (flip_en && (p == flip_pos[i]));
        mon_ones[i] += int'(b);
        if (p == rep_of(i) - 1) begin
          mon_rec[i][mon_n[i]/rep_of(i)] = (2*mon_ones[i] > rep_of(i));
          mon_ones[i] = 0;
          flip_pos[i] = $urandom_range(0, rep_of(i) - 1);
        end
        mon_n[i]++;
        if (mon_n[i] == DW*rep_of(i)) begin
          if (sentq[i].size() == 0)
            chk($sformatf("vote_extra[%0d]", i), 32'(mon_rec[i]), 32'hdead);
          else
            chk($sformatf("vote[%0d]", i), 32'(mon_rec[i]),
                32'(sentq[i].pop_front()));
          mon_n[i] = 0;
        end
      end
    end

    if (txf[0]) begin
      if (!prev_txf) cap_n = 0;
      if (cap_n < DW*R0) cap[cap_n] = txb[0];
      cap_n++;
      flen++;
    end
    prev_txf = txf[0];
    if (dn[0]) begin
      chk("frame_len", 32'(flen), 32'(DW*R0));
      flen = 0;
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_done0(int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      step(1);
      if (dn[0]) begin
        at = cyc;
        return;
      end
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int h, t1, t2;
    bit ok;
    rst = 1'b1;
    vin = '0;
    din = '0;
    step(2);
    rst = 1'b0;
    step(20);

    din[0] = 8'hA5;
    vin[0] = 1'b1;
    step(1);
    h = cyc;
    vin[0] = 1'b0;
    wait_done0(40, t1);
    chk("a5_pattern", 32'(cap), 32'(24'b111000111000000111000111));
    chk("a5_done_at", 32'(t1 - h), 32'(DW*R0));
    step(1);

    din[0] = 8'hFF;
    vin[0] = 1'b1;
    step(1);
    din[0] = 8'h00;
    wait_done0(40, t1);
    wait_done0(40, t2);
    vin[0] = 1'b0;
    chk("b2b_spacing", 32'(t2 - t1), 32'(DW*R0 + 1));
    chk("b2b_cap", 32'(cap), 32'(expand(8'h00)));
    step(2);

    din[0] = 8'h81;
    vin[0] = 1'b1;
    step(1);
    din[0] = 8'h3C;
    vin[0] = 1'b0;
    step(5);
    vin[0] = 1'b1;
    step(2);
    vin[0] = 1'b0;
    wait_done0(40, t1);
    chk("ignore_cap", 32'(cap), 32'(expand(8'h81)));
    step(2);

    din[0] = 8'h5A;
    vin[0] = 1'b1;
    step(1);
    vin[0] = 1'b0;
    step(10);
    rst = 1'b1;
    step(1);
    chk("rst_frame", 32'(txf[0]), 32'd0);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_done", 32'(dn[0]), 32'd0);
    rst = 1'b0;
    step(2);
    din[0] = 8'hC3;
    vin[0] = 1'b1;
    step(1);
    vin[0] = 1'b0;
    wait_done0(40, t1);
    chk("c3_cap", 32'(cap), 32'(expand(8'hC3)));
    step(1);

    flip_en = 1;
    ok = 0;
    for (int c = 0; c < 60000; c++) begin
      if (started[0] >= 1000 && started[1] >= 1000) begin
        ok = 1;
        break;
      end
      for (int i = 0; i < 2; i++) begin
        vin[i] = (started[i] < 1000) && ($urandom_range(0, 3) != 0);
        din[i] = DW'($urandom);
      end
      step(1);
    end
    vin = '0;
    chk("rand_budget", 32'(ok), 32'd1);
    for (int c = 0; c < 200; c++) begin
      if (!m_act[0] && !m_act[1]) break;
      step(1);
    end
    step(2);
    chk("drain_q0", 32'(sentq[0].size()), 32'd0);
    chk("drain_q1", 32'(sentq[1].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
